// File: rtl/adder_result_stage.sv
// Result stage behind a 32-bit adder: derives {N,Z,C,V}, buffers results in a
// 2-entry FIFO, and keeps the chain carry/zero, overflow sticky and op counter.
module adder_result_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    input  logic              in_z,
    input  logic              in_n,
    input  logic              in_chain,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [3:0]        out_flags,
    output logic              carry_q,
    output logic              ovf_sticky,
    input  logic              clr_sticky,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    occ_t occ_q, occ_d;

    logic signed [DATA_W-1:0] a_p0, b_p0, s_p0;
    logic                     v_p0, z_p0;
    logic [3:0]               flags_p0;
    logic                     accept, pop, zc_q;

    logic [DATA_W-1:0] head_sum_p1, tail_sum_p1;
    logic [3:0]        head_flags_p1, tail_flags_p1;

    // Two's-complement overflow: like-signed operands giving an opposite-signed sum.
    function automatic logic ovf_f(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] s);
        return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
    endfunction

    assign in_ready  = (occ_q != FULL);
    assign out_valid = (occ_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Stage p0: flag derivation from the raw adder outputs
    assign a_p0     = in_a;
    assign b_p0     = in_b;
    assign s_p0     = in_sum;
    assign v_p0     = ovf_f(a_p0, b_p0, s_p0);
    assign z_p0     = in_chain ? (in_z & zc_q) : in_z;
    assign flags_p0 = {in_n, z_p0, in_cout, v_p0};

    always_comb begin
        occ_d = occ_q;
        case (occ_q)
            EMPTY: if (accept) occ_d = ONE;
            ONE: begin
                if (accept && !pop)      occ_d = FULL;
                else if (!accept && pop) occ_d = EMPTY;
            end
            FULL:    if (pop) occ_d = ONE;
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= EMPTY;
        else        occ_q <= occ_d;
    end

    // Stage p1: head always holds the oldest entry so outputs come straight from it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_sum_p1   <= '0;
            head_flags_p1 <= '0;
            tail_sum_p1   <= '0;
            tail_flags_p1 <= '0;
        end else begin
            case (occ_q)
                EMPTY: if (accept) begin
                    head_sum_p1   <= in_sum;
                    head_flags_p1 <= flags_p0;
                end
                ONE: begin
                    if (accept && pop) begin
                        head_sum_p1   <= in_sum;
                        head_flags_p1 <= flags_p0;
                    end else if (accept) begin
                        tail_sum_p1   <= in_sum;
                        tail_flags_p1 <= flags_p0;
                    end
                end
                FULL: if (pop) begin
                    head_sum_p1   <= tail_sum_p1;
                    head_flags_p1 <= tail_flags_p1;
                end
                default: ;
            endcase
        end
    end

    assign out_sum   = head_sum_p1;
    assign out_flags = head_flags_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zc_q       <= 1'b1;
            carry_q    <= 1'b0;
            ovf_sticky <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                zc_q     <= z_p0;
                carry_q  <= in_cout;
                op_count <= op_count + 16'd1;
            end
            // Set outranks clear when both land in the same cycle.
            if (accept && v_p0) ovf_sticky <= 1'b1;
            else if (clr_sticky) ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: doc/adder_result_stage.md
ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: port clk (rising edge) and port rst_n (asynchronous, active-low).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream adder result valid.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 in_a, in_b  input  32 each  operands presented to the 32-bit adder (used for overflow).
REQ-007 in_sum  input  32  adder Sum.
REQ-008 in_cout, in_z, in_n  input  1 each  adder Cout, Z, N.
REQ-009 in_chain  input  1  word is the upper word of a multi-word add; Z accumulates over the chain.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_sum  output  32  head entry sum.
REQ-013 out_flags  output  4  head entry flags {N,Z,C,V}, bit3..bit0.
REQ-014 carry_q  output  1  Cout of last accepted word; fed back as adder Cin for chained words.
REQ-015 ovf_sticky  output  1  set when any accepted word has V=1.
REQ-016 clr_sticky  input  1  clears ovf_sticky.
REQ-017 op_count  output  16  number of accepted words, wrapping.

Function
REQ-018 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; pop SHALL occur with out_valid=1 and out_ready=1.
REQ-019 Storage SHALL be a 2-entry FIFO; occupancy states EMPTY, ONE, FULL.
REQ-020 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without pop; ONE->EMPTY on pop without accept; ONE->ONE on accept and pop together; FULL->ONE on pop; all other cases hold.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, derived only from registered state (no combinational path from out_ready).
REQ-022 out_valid SHALL be 1 in ONE and FULL; out_sum/out_flags SHALL show the oldest entry; order SHALL be preserved.
REQ-023 Latency: a word accepted at edge k SHALL appear on out_* in the cycle after edge k when the FIFO was EMPTY.
REQ-024 Stored N = in_n; C = in_cout; V = (in_a[31]==in_b[31]) & (in_sum[31]!=in_a[31]).
REQ-025 Stored Z = in_z when in_chain=0; Z = in_z & zc when in_chain=1, where zc is an internal register holding the stored Z of the last accepted word (reset 1).
REQ-026 zc and carry_q SHALL update on every accept, and only on accept.
REQ-027 ovf_sticky SHALL set on an accept with V=1 and clear on clr_sticky=1; when both occur in one cycle, set SHALL win.
REQ-028 op_count SHALL increment by 1 per accept and wrap 0xFFFF->0x0000.
REQ-029 out_* content while out_valid=0 is don't-care except immediately after reset.

Reset
REQ-030 While rst_n=0, independent of clk: FIFO EMPTY; out_valid=0; in_ready=1; out_sum=0; out_flags=0; carry_q=0; ovf_sticky=0; op_count=0; zc=1.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; no entry SHALL be presented after release.

Verification
REQ-032 in_a=0x7FFFFFFF, in_b=0x00000001, in_sum=0x80000000, cout=0, z=0, n=1 -> out_flags=1001b, ovf_sticky=1, op_count=1.
REQ-033 in_a=0xFFFFFFFF, in_b=0x00000001, in_sum=0, cout=1, z=1, n=0 -> out_flags=0110b, carry_q=1.
REQ-034 Chain: low word sum=0, z=1, chain=0, then upper word sum=0x00000001, z=0, chain=1 -> upper Z=0. Then low sum=0, z=1, chain=0, then upper sum=0, z=1, chain=1 -> upper Z=1.
REQ-035 out_ready=0 with 3 consecutive in_valid words A,B,C -> in_ready=0 after B; C is held upstream. Raise out_ready -> outputs A,B,C in order, one pop per cycle.
REQ-036 FIFO FULL, rst_n pulsed low between edges -> out_valid=0, in_ready=1, op_count=0 immediately; after release no stale entry appears.
REQ-037 Preload op_count to 0xFFFF via accepts, then accept with V=1 while clr_sticky=1 -> op_count=0x0000, ovf_sticky=1. Next cycle clr_sticky=1 with no accept -> ovf_sticky=0.
